vpe_lane_sched: RTL and testbench

Schedules multiply/accumulate jobs from several requesters onto the lanes of the VPE array, one lane per parallel slice.
- Arbitrates round-robin among requesters and picks the lowest-index free lane.
- Holds that lane's mode (1 = scalar, 0 = vector) on the lane's control input for the fixed pipeline latency.
- Reports completion with lane and requester tags.
- Sits between the tile-fetch front end and the VPE datapath.

---
 rtl/vpe_sched_pkg.sv | 20 ++
 rtl/vpe_lane_sched_rr_arbiter.sv | 36 +++
 rtl/vpe_lane_sched.sv | 198 +++++++++++++++++++
 tb/tb_vpe_lane_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpe_sched_pkg.sv
// Shared types and constants for the VPE lane scheduler.
// Per-lane state and mode encodings used by vpe_lane_sched.
package vpe_sched_pkg;

    // Field widths are fixed here and sized to cover any practical LAT / NUM_REQ.
    localparam int SCHED_CNT_W   = 16;
    localparam int SCHED_OWNER_W = 8;

    // Lane control encodings driven on lane_mode_o.
    localparam logic MODE_VEC  = 1'b0;
    localparam logic MODE_SCAL = 1'b1;

    typedef struct packed {
        logic                     busy;
        logic [SCHED_CNT_W-1:0]   cnt;
        logic                     mode;
        logic [SCHED_OWNER_W-1:0] owner;
    } lane_state_t;

endpackage

// File: rtl/vpe_lane_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i
// (wrapping), only when en_i is high. One-hot grant plus binary index.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o
);

    logic found;
    int   j;

    // Scan requesters starting at the pointer and stop at the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (en_i && !found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
    end

endmodule

// File: rtl/vpe_lane_sched.sv
// VPE lane scheduler: round-robin grant among requesters, lowest free lane
// selection, fixed-latency countdown per lane, tagged completion report.
// Optional performance counters are enabled with the macro VPE_SCHED_PERF_EN;
// without it perf_issue_o / perf_stall_o are tied to 0.
module vpe_lane_sched
    import vpe_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_LANES = 6,
    parameter int LAT       = 7,
    parameter int REQ_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ-1:0]   req_mode_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 issue_valid_o,
    output logic [LANE_W-1:0]    issue_lane_o,
    output logic [REQ_W-1:0]     issue_req_o,
    output logic [NUM_LANES-1:0] lane_mode_o,
    output logic [NUM_LANES-1:0] lane_busy_o,
    output logic                 cmpl_valid_o,
    output logic [LANE_W-1:0]    cmpl_lane_o,
    output logic [REQ_W-1:0]     cmpl_req_o,
    output logic [31:0]          perf_issue_o,
    output logic [31:0]          perf_stall_o
);

    if (LAT < 1) begin : g_lat_chk
        $error("vpe_lane_sched: LAT must be >= 1");
    end

    lane_state_t            lane_q [NUM_LANES];
    lane_state_t            lane_d [NUM_LANES];
    logic [REQ_W-1:0]       rr_q;
    logic [REQ_W-1:0]       rr_d;

    logic [NUM_LANES-1:0]   lane_free;
    logic [NUM_LANES-1:0]   lane_done;
    logic                   any_free;
    logic [LANE_W-1:0]      free_idx;
    logic [LANE_W-1:0]      done_idx;
    logic [REQ_W-1:0]       done_owner;

    logic                   arb_en;
    logic [NUM_REQ-1:0]     gnt;
    logic [REQ_W-1:0]       gnt_idx;
    logic                   issue;

    // Lane status: a lane finishing this cycle counts as free so it can be reused at once.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_done[k] = lane_q[k].busy && (lane_q[k].cnt == SCHED_CNT_W'(1));
            lane_free[k] = !lane_q[k].busy || lane_done[k];
        end
    end

    // Priority encoders: lowest free lane for issue, lowest finishing lane for completion.
    always_comb begin
        any_free   = 1'b0;
        free_idx   = '0;
        done_idx   = '0;
        done_owner = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (lane_free[k]) begin
                any_free = 1'b1;
                free_idx = LANE_W'(k);
            end
            if (lane_done[k]) begin
                done_idx   = LANE_W'(k);
                done_owner = lane_q[k].owner[REQ_W-1:0];
            end
        end
    end

    // Reset is folded in so req_ready_o stays low while rst_ni is asserted.
    assign arb_en = rst_ni && !flush_i && any_free;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (REQ_W)
    ) u_arb (
        .req_i (req_valid_i),
        .en_i  (arb_en),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign issue         = |gnt;
    assign req_ready_o   = gnt;
    assign issue_valid_o = issue;
    assign issue_lane_o  = issue ? free_idx : '0;
    assign issue_req_o   = issue ? gnt_idx : '0;

    // Flushed jobs never report, including one that would finish in the flush cycle.
    assign cmpl_valid_o  = (|lane_done) && !flush_i;
    assign cmpl_lane_o   = cmpl_valid_o ? done_idx : '0;
    assign cmpl_req_o    = cmpl_valid_o ? done_owner : '0;

    // Registered lane-facing outputs straight from the lane state.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_mode_o[k] = lane_q[k].mode;
            lane_busy_o[k] = lane_q[k].busy;
        end
    end

    // Next state: flush clears occupancy only; issue loads the chosen lane; busy lanes count down.
    always_comb begin
        rr_d = rr_q;
        if (issue) begin
            rr_d = (gnt_idx == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_d[k] = lane_q[k];
            if (flush_i) begin
                lane_d[k].busy = 1'b0;
                lane_d[k].cnt  = '0;
            end else if (issue && (free_idx == LANE_W'(k))) begin
                lane_d[k].busy  = 1'b1;
                lane_d[k].cnt   = SCHED_CNT_W'(LAT);
                lane_d[k].mode  = req_mode_i[gnt_idx];
                lane_d[k].owner = SCHED_OWNER_W'(gnt_idx);
            end else if (lane_q[k].busy) begin
                lane_d[k].cnt = lane_q[k].cnt - 1'b1;
                if (lane_done[k]) begin
                    lane_d[k].busy = 1'b0;
                end
            end
        end
    end

    // State registers; reset drops every in-flight job.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_q[k] <= '{busy: 1'b0, cnt: '0, mode: MODE_VEC, owner: '0};
            end
        end else begin
            rr_q <= rr_d;
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

    // One issue per cycle means at most one lane can finish per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(lane_done));
            for (int k = 0; k < NUM_LANES; k++) begin
                assert (lane_q[k].owner < SCHED_OWNER_W'(NUM_REQ));
            end
        end
    end

`ifdef VPE_SCHED_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_issue_d;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;

    // Saturating issue and stall counters; flush does not clear them.
    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_stall_d = perf_stall_q;
        if (issue && (perf_issue_q != '1)) begin
            perf_issue_d = perf_issue_q + 32'd1;
        end
        if ((|req_valid_i) && !any_free && !flush_i && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_o = perf_issue_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_issue_o = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_vpe_lane_sched.sv
// Testbench for vpe_lane_sched: default instance (4 req, 6 lanes, LAT 7)
// with a completion scoreboard, plus a 1-lane LAT=1 instance for fairness.
module tb_vpe_lane_sched;

`ifdef VPE_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // Instance A signals
    logic       a_flush;
    logic [3:0] a_req_valid, a_req_mode, a_req_ready;
    logic       a_issue_valid;
    logic [2:0] a_issue_lane;
    logic [1:0] a_issue_req;
    logic [5:0] a_lane_mode, a_lane_busy;
    logic       a_cmpl_valid;
    logic [2:0] a_cmpl_lane;
    logic [1:0] a_cmpl_req;
    logic [31:0] a_perf_issue, a_perf_stall;

    // Instance B signals
    logic       b_flush;
    logic [3:0] b_req_valid, b_req_mode, b_req_ready;
    logic       b_issue_valid;
    logic [0:0] b_issue_lane;
    logic [1:0] b_issue_req;
    logic [0:0] b_lane_mode, b_lane_busy;
    logic       b_cmpl_valid;
    logic [0:0] b_cmpl_lane;
    logic [1:0] b_cmpl_req;
    logic [31:0] b_perf_issue, b_perf_stall;

    vpe_lane_sched #(.NUM_REQ(4), .NUM_LANES(6), .LAT(7)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
        .req_valid_i(a_req_valid), .req_mode_i(a_req_mode), .req_ready_o(a_req_ready),
        .issue_valid_o(a_issue_valid), .issue_lane_o(a_issue_lane), .issue_req_o(a_issue_req),
        .lane_mode_o(a_lane_mode), .lane_busy_o(a_lane_busy),
        .cmpl_valid_o(a_cmpl_valid), .cmpl_lane_o(a_cmpl_lane), .cmpl_req_o(a_cmpl_req),
        .perf_issue_o(a_perf_issue), .perf_stall_o(a_perf_stall)
    );

    vpe_lane_sched #(.NUM_REQ(4), .NUM_LANES(1), .LAT(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
        .req_valid_i(b_req_valid), .req_mode_i(b_req_mode), .req_ready_o(b_req_ready),
        .issue_valid_o(b_issue_valid), .issue_lane_o(b_issue_lane), .issue_req_o(b_issue_req),
        .lane_mode_o(b_lane_mode), .lane_busy_o(b_lane_busy),
        .cmpl_valid_o(b_cmpl_valid), .cmpl_lane_o(b_cmpl_lane), .cmpl_req_o(b_cmpl_req),
        .perf_issue_o(b_perf_issue), .perf_stall_o(b_perf_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int lane;
        int req;
        int due;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_exp(input int lane, input int req);
        exp_q.push_back('{lane: lane, req: req, due: cyc + 7});
    endtask

    // Completion scoreboard for instance A.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL cmpl_missing lane=%0d req=%0d due=%0d now=%0d",
                         exp_q[0].lane, exp_q[0].req, exp_q[0].due, cyc);
                void'(exp_q.pop_front());
            end
            if (a_cmpl_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL cmpl_unexpected got lane=%0d req=%0d at cyc=%0d, expected none",
                             a_cmpl_lane, a_cmpl_req, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(a_cmpl_lane) != e.lane || int'(a_cmpl_req) != e.req || cyc != e.due) begin
                        bad++;
                        $display("FAIL cmpl_tag got lane=%0d req=%0d cyc=%0d, expected lane=%0d req=%0d cyc=%0d",
                                 a_cmpl_lane, a_cmpl_req, cyc, e.lane, e.req, e.due);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        a_req_valid = '0; a_req_mode = '0; a_flush = 1'b0;
        b_req_valid = '0; b_req_mode = '0; b_flush = 1'b0;
        exp_q.delete();
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_req_valid = 4'b1111;
        @(negedge clk);
        total++;
        if (a_req_ready !== 4'b0000 || a_issue_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_grant ready=%b issue=%b, expected 0000/0", a_req_ready, a_issue_valid);
        end
        total++;
        if (a_lane_busy !== 6'b0 || a_lane_mode !== 6'b0 || a_cmpl_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_lanes busy=%b mode=%b cmpl=%b, expected 0", a_lane_busy, a_lane_mode, a_cmpl_valid);
        end
        total++;
        if (a_perf_issue !== 32'd0 || a_perf_stall !== 32'd0) begin
            bad++;
            $display("FAIL reset_perf issue=%0d stall=%0d, expected 0/0", a_perf_issue, a_perf_stall);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        a_req_valid = 4'b0100;
        a_req_mode  = 4'b0100;
        @(negedge clk);
        total++;
        if (a_req_ready !== 4'b0100 || a_issue_valid !== 1'b1 || a_issue_lane !== 3'd0 || a_issue_req !== 2'd2) begin
            bad++;
            $display("FAIL single_issue ready=%b v=%b lane=%0d req=%0d, expected 0100/1/0/2",
                     a_req_ready, a_issue_valid, a_issue_lane, a_issue_req);
        end
        push_exp(0, 2);
        nxt();
        a_req_valid = '0;
        @(negedge clk);
        total++;
        if (a_lane_mode !== 6'b000001 || a_lane_busy !== 6'b000001) begin
            bad++;
            $display("FAIL single_mode mode=%b busy=%b, expected 000001/000001", a_lane_mode, a_lane_busy);
        end
        repeat (7) nxt();
        @(negedge clk);
        total++;
        if (exp_q.size() != 0 || a_lane_busy !== 6'b0 || a_lane_mode !== 6'b000001) begin
            bad++;
            $display("FAIL single_drain pending=%0d busy=%b mode=%b, expected 0/000000/000001",
                     exp_q.size(), a_lane_busy, a_lane_mode);
        end
    endtask

    task automatic test_all_lanes();
        do_reset();
        a_req_valid = 4'b1111;
        a_req_mode  = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (a_req_ready !== 4'(1 << (c % 4)) || a_issue_lane !== 3'(c) || a_issue_req !== 2'(c % 4)) begin
                bad++;
                $display("FAIL fill_grant c=%0d ready=%b lane=%0d req=%0d, expected %b/%0d/%0d",
                         c, a_req_ready, a_issue_lane, a_issue_req, 4'(1 << (c % 4)), c, c % 4);
            end
            push_exp(c, c % 4);
            nxt();
        end
        @(negedge clk);
        total++;
        if (a_req_ready !== 4'b0000 || a_issue_valid !== 1'b0 || a_lane_busy !== 6'b111111) begin
            bad++;
            $display("FAIL full_stall ready=%b v=%b busy=%b, expected 0000/0/111111",
                     a_req_ready, a_issue_valid, a_lane_busy);
        end
        nxt();
        @(negedge clk);
        total++;
        if (a_req_ready !== 4'b0100 || a_issue_lane !== 3'd0 || a_issue_req !== 2'd2) begin
            bad++;
            $display("FAIL reuse_grant ready=%b lane=%0d req=%0d, expected 0100/0/2",
                     a_req_ready, a_issue_lane, a_issue_req);
        end
        total++;
        if (a_perf_stall !== (PERF ? 32'd1 : 32'd0)) begin
            bad++;
            $display("FAIL perf_stall got=%0d expected=%0d", a_perf_stall, PERF ? 1 : 0);
        end
        push_exp(0, 2);
        nxt();
        a_req_valid = '0;
        @(negedge clk);
        total++;
        if (a_perf_issue !== (PERF ? 32'd7 : 32'd0)) begin
            bad++;
            $display("FAIL perf_issue got=%0d expected=%0d", a_perf_issue, PERF ? 7 : 0);
        end
        repeat (8) nxt();
        @(negedge clk);
        total++;
        if (exp_q.size() != 0 || a_lane_busy !== 6'b0 || a_lane_mode !== 6'b101010) begin
            bad++;
            $display("FAIL fill_drain pending=%0d busy=%b mode=%b, expected 0/000000/101010",
                     exp_q.size(), a_lane_busy, a_lane_mode);
        end
    endtask

    task automatic test_flush();
        do_reset();
        a_req_valid = 4'b0010;
        a_req_mode  = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (a_issue_valid !== 1'b1 || a_issue_lane !== 3'(c) || a_issue_req !== 2'd1) begin
                bad++;
                $display("FAIL flush_fill c=%0d v=%b lane=%0d req=%0d, expected 1/%0d/1",
                         c, a_issue_valid, a_issue_lane, a_issue_req, c);
            end
            nxt();
        end
        a_flush = 1'b1;
        @(negedge clk);
        total++;
        if (a_req_ready !== 4'b0000 || a_issue_valid !== 1'b0 || a_lane_busy !== 6'b000111) begin
            bad++;
            $display("FAIL flush_cycle ready=%b v=%b busy=%b, expected 0000/0/000111",
                     a_req_ready, a_issue_valid, a_lane_busy);
        end
        nxt();
        a_flush     = 1'b0;
        a_req_valid = 4'b0001;
        a_req_mode  = 4'b0001;
        @(negedge clk);
        total++;
        if (a_lane_busy !== 6'b0 || a_lane_mode !== 6'b000111) begin
            bad++;
            $display("FAIL flush_clear busy=%b mode=%b, expected 000000/000111", a_lane_busy, a_lane_mode);
        end
        total++;
        if (a_req_ready !== 4'b0001 || a_issue_lane !== 3'd0) begin
            bad++;
            $display("FAIL flush_reissue ready=%b lane=%0d, expected 0001/0", a_req_ready, a_issue_lane);
        end
        push_exp(0, 0);
        nxt();
        a_req_valid = '0;
        repeat (8) nxt();
        @(negedge clk);
        total++;
        if (exp_q.size() != 0 || a_lane_busy !== 6'b0) begin
            bad++;
            $display("FAIL flush_drain pending=%0d busy=%b, expected 0/000000", exp_q.size(), a_lane_busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_req_valid = 4'b1000;
        a_req_mode  = 4'b1100;
        @(negedge clk);
        push_exp(0, 3);
        nxt();
        a_req_valid = 4'b0100;
        @(negedge clk);
        total++;
        if (a_issue_lane !== 3'd1 || a_issue_req !== 2'd2) begin
            bad++;
            $display("FAIL rmid_issue lane=%0d req=%0d, expected 1/2", a_issue_lane, a_issue_req);
        end
        push_exp(1, 2);
        nxt();
        a_req_valid = '0;
        repeat (2) nxt();
        a_req_valid = 4'b1111;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if (a_lane_busy !== 6'b0 || a_lane_mode !== 6'b0 || a_req_ready !== 4'b0 ||
            a_issue_valid !== 1'b0 || a_cmpl_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_async busy=%b mode=%b ready=%b v=%b cmpl=%b, expected all 0",
                     a_lane_busy, a_lane_mode, a_req_ready, a_issue_valid, a_cmpl_valid);
        end
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (a_req_ready !== 4'b0001 || a_issue_lane !== 3'd0 || a_issue_req !== 2'd0) begin
            bad++;
            $display("FAIL rmid_first ready=%b lane=%0d req=%0d, expected 0001/0/0",
                     a_req_ready, a_issue_lane, a_issue_req);
        end
        push_exp(0, 0);
        nxt();
        a_req_valid = '0;
        repeat (8) nxt();
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rmid_drain pending=%0d, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        int want;
        do_reset();
        prev = 0;
        b_req_valid = 4'b1001;
        b_req_mode  = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            want = (c % 2 == 0) ? 0 : 3;
            @(negedge clk);
            total++;
            if (b_req_ready !== 4'(1 << want) || b_issue_lane !== 1'b0 || b_issue_req !== 2'(want)) begin
                bad++;
                $display("FAIL b2b_grant c=%0d ready=%b req=%0d, expected %b/%0d",
                         c, b_req_ready, b_issue_req, 4'(1 << want), want);
            end
            total++;
            if (c == 0) begin
                if (b_cmpl_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_cmpl0 got=%b expected=0", b_cmpl_valid);
                end
            end else if (b_cmpl_valid !== 1'b1 || b_cmpl_req !== 2'(prev) || b_lane_busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_cmpl c=%0d v=%b req=%0d busy=%b, expected 1/%0d/1",
                         c, b_cmpl_valid, b_cmpl_req, b_lane_busy, prev);
            end
            prev = want;
            nxt();
        end
        b_req_valid = '0;
        @(negedge clk);
        total++;
        if (b_cmpl_valid !== 1'b1 || b_cmpl_req !== 2'(prev) || b_req_ready !== 4'b0) begin
            bad++;
            $display("FAIL b2b_last v=%b req=%0d ready=%b, expected 1/%0d/0000",
                     b_cmpl_valid, b_cmpl_req, b_req_ready, prev);
        end
        nxt();
        @(negedge clk);
        total++;
        if (b_lane_busy !== 1'b0 || b_cmpl_valid !== 1'b0 || b_lane_mode !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle busy=%b cmpl=%b mode=%b, expected 0/0/0",
                     b_lane_busy, b_cmpl_valid, b_lane_mode);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 1'b0; a_req_valid = '0; a_req_mode = '0;
        b_flush = 1'b0; b_req_valid = '0; b_req_mode = '0;
        #1;
        test_reset();
        test_single();
        test_all_lanes();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
